alu_mc: RTL



---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu_mul_seq.sv | 52 +++++
 rtl/alu_mc.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared op-code map, FSM state type and legality check for the multi-cycle ALU.
package alu_pkg;

  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_OR    = 4'b0001;
  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_XOR   = 4'b0011;
  localparam logic [3:0] ALU_NOR   = 4'b0100;
  localparam logic [3:0] ALU_SLTU  = 4'b0101;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_SLT   = 4'b0111;
  localparam logic [3:0] ALU_SLL   = 4'b1000;
  localparam logic [3:0] ALU_SRL   = 4'b1001;
  localparam logic [3:0] ALU_SRA   = 4'b1010;
  localparam logic [3:0] ALU_MUL   = 4'b1100;
  localparam logic [3:0] ALU_MULHU = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  function automatic logic is_legal_op(input logic [3:0] op, input logic enable_mul);
    case (op)
      ALU_AND, ALU_OR, ALU_ADD, ALU_XOR, ALU_NOR, ALU_SLTU, ALU_SUB, ALU_SLT,
      ALU_SLL, ALU_SRL, ALU_SRA: return 1'b1;
      ALU_MUL, ALU_MULHU:        return enable_mul;
      default:                   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Radix-2 shift-add unsigned multiplier: one multiplier bit per cycle, WIDTH cycles.
module alu_mul_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   step_sum;

  // Upper half accumulates; lower half starts as the multiplier and shifts out LSB-first.
  always_comb begin
    step_sum = {1'b0, product[2*WIDTH-1:WIDTH]};
    if (product[0]) step_sum = step_sum + {1'b0, mcand};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand   <= '0;
      product <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        mcand   <= a;
        product <= {{WIDTH{1'b0}}, b};
        cnt     <= '0;
        busy    <= 1'b1;
      end else if (busy) begin
        product <= {step_sum, product[WIDTH-1:1]};
        cnt     <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with registered result/flags and valid/ready handshakes on both sides.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ENABLE_MUL = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Negative,
  output logic             Carry,
  output logic             Overflow,
  output logic             Illegal
);

  localparam int SW = $clog2(WIDTH);

  state_t state, next_state;

  logic             legal, is_mul, is_sub;
  logic             load_alu, load_mul, mul_start, op_hi;
  logic [WIDTH-1:0] b_eff, sum, alu_res, mul_res;
  logic             cout, alu_carry, alu_ovf;
  logic [SW-1:0]    shamt;
  logic             mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign legal  = is_legal_op(ALUControl, ENABLE_MUL != 0);
  assign is_mul = legal && (ALUControl == ALU_MUL || ALUControl == ALU_MULHU);
  assign is_sub = (ALUControl == ALU_SUB);
  assign shamt  = SrcB[SW-1:0];

  always_comb begin
    b_eff      = is_sub ? ~SrcB : SrcB;
    {cout, sum} = {1'b0, SrcA} + {1'b0, b_eff} + {{WIDTH{1'b0}}, is_sub};
    alu_res    = '0;
    alu_carry  = 1'b0;
    alu_ovf    = 1'b0;
    case (ALUControl)
      ALU_AND:  alu_res = SrcA & SrcB;
      ALU_OR:   alu_res = SrcA | SrcB;
      ALU_XOR:  alu_res = SrcA ^ SrcB;
      ALU_NOR:  alu_res = ~(SrcA | SrcB);
      ALU_ADD, ALU_SUB: begin
        alu_res   = sum;
        alu_carry = cout;
        alu_ovf   = (SrcA[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != SrcA[WIDTH-1]);
      end
      ALU_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
      ALU_SLTU: alu_res = {{(WIDTH-1){1'b0}}, SrcA < SrcB};
      ALU_SLL:  alu_res = SrcA << shamt;
      ALU_SRL:  alu_res = SrcA >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(SrcA) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  generate
    if (ENABLE_MUL != 0) begin : g_mul
      alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (mul_start),
        .a       (SrcA),
        .b       (SrcB),
        .busy    (mul_busy),
        .done    (mul_done),
        .product (mul_product)
      );
    end else begin : g_no_mul
      assign mul_busy    = 1'b0;
      assign mul_done    = 1'b0;
      assign mul_product = '0;
    end
  endgenerate

  assign mul_res = op_hi ? mul_product[2*WIDTH-1:WIDTH] : mul_product[WIDTH-1:0];

  always_comb begin
    next_state = state;
    load_alu   = 1'b0;
    load_mul   = 1'b0;
    mul_start  = 1'b0;
    case (state)
      S_IDLE: if (in_valid) begin
        if (is_mul) begin
          mul_start  = 1'b1;
          next_state = S_MUL;
        end else begin
          load_alu   = 1'b1;
          next_state = S_DONE;
        end
      end
      S_MUL: if (mul_done && !mul_busy) begin
        load_mul   = 1'b1;
        next_state = S_DONE;
      end
      S_DONE: if (out_ready) next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      op_hi     <= 1'b0;
      ALUResult <= '0;
      Zero      <= 1'b1;
      Negative  <= 1'b0;
      Carry     <= 1'b0;
      Overflow  <= 1'b0;
      Illegal   <= 1'b0;
    end else begin
      state <= next_state;
      if (mul_start) op_hi <= (ALUControl == ALU_MULHU);
      if (load_alu) begin
        ALUResult <= alu_res;
        Zero      <= (alu_res == '0);
        Negative  <= alu_res[WIDTH-1];
        Carry     <= alu_carry;
        Overflow  <= alu_ovf;
        Illegal   <= !legal;
      end else if (load_mul) begin
        ALUResult <= mul_res;
        Zero      <= (mul_res == '0);
        Negative  <= mul_res[WIDTH-1];
        Carry     <= 1'b0;
        Overflow  <= 1'b0;
        Illegal   <= 1'b0;
      end
    end
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);

endmodule
